nn_param_store: RTL and testbench

Runtime-loadable parameter store for the 2D-conv network, replacing fixed per-build weight packages. It accepts a single valid/ready stream of signed W-bit words and places them into four segments: conv weights, conv biases, dense weights and dense biases. It then serves registered reads to the conv and dense datapaths. Channel count, kernel size, dense fan-in/fan-out and word width are all parameters, so the same RTL covers every network variant.

---
 rtl/nn_param_store.sv | 268 ++++++++++++++++++++++++++
 tb/tb_nn_param_store.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_param_store.sv
// ============================================================================
// Module   : nn_param_store
// Purpose  : Runtime-loadable parameter store for the 2D-conv network. A
//            single valid/ready stream of W-bit words fills four segments
//            (conv weights, conv biases, dense weights, dense biases) in that
//            order. Registered one-cycle reads then serve a conv kernel plus
//            its bias, or one dense input column, to the datapaths.
// Ports    : clk, reset                     - clock, synchronous active-high reset
//            load_start                     - pulse: restart the load at segment 0
//            ld_data/ld_valid/ld_ready      - parameter load stream
//            loaded, load_done              - full set present / final-beat pulse
//            conv_rd_en/ch -> conv_w/b/valid - conv kernel read (1-cycle latency)
//            dl_rd_en/idx  -> dl_w/valid     - dense column read (1-cycle latency)
//            dl_b                           - all dense biases, 0 while not loaded
//            rd_err                         - pulse: bad address or read while not loaded
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_param_store #(
  parameter int W       = 4,
  parameter int CONV_CH = 2,
  parameter int K       = 3,
  parameter int DL_IN   = 128,
  parameter int DL_OUT  = 10,
  // Read-address widths. They may be set wider than needed so that
  // out-of-range addresses can be presented.
  parameter int CH_W    = (CONV_CH > 1) ? $clog2(CONV_CH) : 1,
  parameter int IDX_W   = (DL_IN > 1) ? $clog2(DL_IN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [W-1:0]          ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  loaded,
  output logic                  load_done,
  input  logic                  conv_rd_en,
  input  logic [CH_W-1:0]       conv_rd_ch,
  output logic [K*K*W-1:0]      conv_w,
  output logic [W-1:0]          conv_b,
  output logic                  conv_rd_valid,
  input  logic                  dl_rd_en,
  input  logic [IDX_W-1:0]      dl_rd_idx,
  output logic [DL_OUT*W-1:0]   dl_w,
  output logic [DL_OUT*W-1:0]   dl_b,
  output logic                  dl_rd_valid,
  output logic                  rd_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NTAP    = K * K;
  localparam int NCW     = CONV_CH * NTAP;
  localparam int NCB     = CONV_CH;
  localparam int NDW     = DL_IN * DL_OUT;
  localparam int NDB     = DL_OUT;

  // Index widths that exactly address each storage dimension.
  localparam int CH_SEL  = (CONV_CH > 1) ? $clog2(CONV_CH) : 1;
  localparam int IDX_SEL = (DL_IN > 1)   ? $clog2(DL_IN)   : 1;
  localparam int TAP_SEL = (NTAP > 1)    ? $clog2(NTAP)    : 1;
  localparam int OUT_SEL = (DL_OUT > 1)  ? $clog2(DL_OUT)  : 1;

  localparam int ROW_W   = max2(CH_SEL, IDX_SEL);
  localparam int COL_W   = max2(max2(TAP_SEL, OUT_SEL), CH_SEL);
  localparam int MAXSEG  = max2(max2(NCW, NCB), max2(NDW, NDB));
  localparam int CNT_W   = $clog2(MAXSEG + 1);

  localparam logic [CNT_W-1:0] CW_LAST  = CNT_W'(NCW - 1);
  localparam logic [CNT_W-1:0] CB_LAST  = CNT_W'(NCB - 1);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(NDW - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(NDB - 1);
  localparam logic [COL_W-1:0] TAP_LAST = COL_W'(NTAP - 1);
  localparam logic [COL_W-1:0] OUT_LAST = COL_W'(DL_OUT - 1);
  localparam logic [31:0]      CONV_CH_U = 32'(CONV_CH);
  localparam logic [31:0]      DL_IN_U   = 32'(DL_IN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LD_CW = 3'd1;
  localparam logic [2:0] S_LD_CB = 3'd2;
  localparam logic [2:0] S_LD_DW = 3'd3;
  localparam logic [2:0] S_LD_DB = 3'd4;
  localparam logic [2:0] S_READY = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  // row/col track the 2-D storage position alongside the flat segment
  // counter, so no division is needed to place a beat.
  logic [ROW_W-1:0] row_q,   row_d;
  logic [COL_W-1:0] col_q,   col_d;

  logic             accept;
  logic             seg_end;
  logic [CNT_W-1:0] seg_last;

  // Parameter storage: deliberately not reset.
  logic [W-1:0] cw_q [CONV_CH][NTAP];
  logic [W-1:0] cb_q [CONV_CH];
  logic [W-1:0] dw_q [DL_IN][DL_OUT];
  logic [W-1:0] db_q [DL_OUT];

  logic [K*K*W-1:0]    conv_w_q;
  logic [W-1:0]        conv_b_q;
  logic                conv_rd_valid_q;
  logic [DL_OUT*W-1:0] dl_w_q;
  logic                dl_rd_valid_q;
  logic                rd_err_q;

  // --------------------------------------------------------------------------
  // Load sequencing
  // --------------------------------------------------------------------------
  always_comb begin
    ld_ready = (state_q == S_LD_CW) || (state_q == S_LD_CB) ||
               (state_q == S_LD_DW) || (state_q == S_LD_DB);
    // A beat coinciding with load_start belongs to the abandoned load.
    accept   = ld_valid && ld_ready && !load_start;

    case (state_q)
      S_LD_CW: seg_last = CW_LAST;
      S_LD_CB: seg_last = CB_LAST;
      S_LD_DW: seg_last = DW_LAST;
      S_LD_DB: seg_last = DB_LAST;
      default: seg_last = '0;
    endcase
    seg_end   = (cnt_q == seg_last);
    load_done = accept && seg_end && (state_q == S_LD_DB);

    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;

    if (load_start) begin
      state_d = S_LD_CW;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
    end else if (accept) begin
      if (seg_end) begin
        cnt_d = '0;
        row_d = '0;
        col_d = '0;
        case (state_q)
          S_LD_CW: state_d = S_LD_CB;
          S_LD_CB: state_d = S_LD_DW;
          S_LD_DW: state_d = S_LD_DB;
          S_LD_DB: state_d = S_READY;
          default: state_d = state_q;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        // Row wrap for the two 2-D segments; bias segments only walk col.
        if (((state_q == S_LD_CW) && (col_q == TAP_LAST)) ||
            ((state_q == S_LD_DW) && (col_q == OUT_LAST))) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (state_q)
        S_LD_CW: cw_q[row_q[CH_SEL-1:0]][col_q[TAP_SEL-1:0]]  <= ld_data;
        S_LD_CB: cb_q[col_q[CH_SEL-1:0]]                      <= ld_data;
        S_LD_DW: dw_q[row_q[IDX_SEL-1:0]][col_q[OUT_SEL-1:0]] <= ld_data;
        S_LD_DB: db_q[col_q[OUT_SEL-1:0]]                     <= ld_data;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read side
  // --------------------------------------------------------------------------
  logic [CH_SEL-1:0]   rd_ch;
  logic [IDX_SEL-1:0]  rd_idx;
  logic [K*K*W-1:0]    conv_pack;
  logic [DL_OUT*W-1:0] dl_pack;
  logic [DL_OUT*W-1:0] db_pack;
  logic                conv_ok;
  logic                dl_ok;

  assign rd_ch   = conv_rd_ch[CH_SEL-1:0];
  assign rd_idx  = dl_rd_idx[IDX_SEL-1:0];
  // Range checks use the full address so widened addresses are caught.
  assign conv_ok = (state_q == S_READY) && (32'(conv_rd_ch) < CONV_CH_U);
  assign dl_ok   = (state_q == S_READY) && (32'(dl_rd_idx) < DL_IN_U);

  for (genvar t = 0; t < NTAP; t++) begin : g_tap
    assign conv_pack[t*W +: W] = cw_q[rd_ch][t];
  end

  for (genvar o = 0; o < DL_OUT; o++) begin : g_out
    assign dl_pack[o*W +: W] = dw_q[rd_idx][o];
    assign db_pack[o*W +: W] = db_q[o];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_w_q        <= '0;
      conv_b_q        <= '0;
      conv_rd_valid_q <= 1'b0;
      dl_w_q          <= '0;
      dl_rd_valid_q   <= 1'b0;
      rd_err_q        <= 1'b0;
    end else begin
      conv_rd_valid_q <= 1'b0;
      dl_rd_valid_q   <= 1'b0;
      rd_err_q        <= 1'b0;
      // Without a request the data registers keep their last value.
      if (conv_rd_en) begin
        if (conv_ok) begin
          conv_w_q        <= conv_pack;
          conv_b_q        <= cb_q[rd_ch];
          conv_rd_valid_q <= 1'b1;
        end else begin
          conv_w_q <= '0;
          conv_b_q <= '0;
          rd_err_q <= 1'b1;
        end
      end
      if (dl_rd_en) begin
        if (dl_ok) begin
          dl_w_q        <= dl_pack;
          dl_rd_valid_q <= 1'b1;
        end else begin
          dl_w_q   <= '0;
          rd_err_q <= 1'b1;
        end
      end
    end
  end

  assign loaded        = (state_q == S_READY);
  assign conv_w        = conv_w_q;
  assign conv_b        = conv_b_q;
  assign conv_rd_valid = conv_rd_valid_q;
  assign dl_w          = dl_w_q;
  assign dl_rd_valid   = dl_rd_valid_q;
  assign rd_err        = rd_err_q;
  // Bias storage is undefined before the first load, so mask it.
  assign dl_b          = loaded ? db_pack : '0;

endmodule

`default_nettype wire

// File: tb/tb_nn_param_store.sv
// ============================================================================
// Module   : tb_nn_param_store
// Purpose  : Self-checking bench for nn_param_store. A flat array holds the
//            parameter image in load order; expected read data is looked up
//            from it by segment offsets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_param_store;

  localparam int W       = 4;
  localparam int CONV_CH = 2;
  localparam int K       = 3;
  localparam int DL_IN   = 128;
  localparam int DL_OUT  = 10;
  localparam int CH_W    = 2;
  localparam int IDX_W   = 8;
  localparam int NTAP    = K * K;
  localparam int NCW     = CONV_CH * NTAP;
  localparam int NCB     = CONV_CH;
  localparam int NDW     = DL_IN * DL_OUT;
  localparam int NDB     = DL_OUT;
  localparam int NTOT    = NCW + NCB + NDW + NDB;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_start;
  logic [W-1:0]        ld_data;
  logic                ld_valid;
  logic                ld_ready;
  logic                loaded;
  logic                load_done;
  logic                conv_rd_en;
  logic [CH_W-1:0]     conv_rd_ch;
  logic [NTAP*W-1:0]   conv_w;
  logic [W-1:0]        conv_b;
  logic                conv_rd_valid;
  logic                dl_rd_en;
  logic [IDX_W-1:0]    dl_rd_idx;
  logic [DL_OUT*W-1:0] dl_w;
  logic [DL_OUT*W-1:0] dl_b;
  logic                dl_rd_valid;
  logic                rd_err;

  always #5 clk = ~clk;

  nn_param_store #(
    .W(W), .CONV_CH(CONV_CH), .K(K), .DL_IN(DL_IN), .DL_OUT(DL_OUT),
    .CH_W(CH_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .loaded(loaded), .load_done(load_done),
    .conv_rd_en(conv_rd_en), .conv_rd_ch(conv_rd_ch), .conv_w(conv_w),
    .conv_b(conv_b), .conv_rd_valid(conv_rd_valid),
    .dl_rd_en(dl_rd_en), .dl_rd_idx(dl_rd_idx), .dl_w(dl_w), .dl_b(dl_b),
    .dl_rd_valid(dl_rd_valid), .rd_err(rd_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: parameter image in load order plus held read data.
  logic [W-1:0]        mem [NTOT];
  bit                  model_loaded;
  logic [NTAP*W-1:0]   exp_cw;
  logic [W-1:0]        exp_cb;
  logic [DL_OUT*W-1:0] exp_dw;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DL_OUT*W-1:0] model_db();
    logic [DL_OUT*W-1:0] v = '0;
    if (model_loaded)
      for (int o = 0; o < DL_OUT; o++) v[o*W +: W] = mem[NCW + NCB + NDW + o];
    return v;
  endfunction

  // pat 0: index mod 16; 1: all ones except final beat = 1; 2: random; 3: zero
  function automatic logic [W-1:0] beat_word(input int pat, input int k);
    case (pat)
      0:       return W'(k % 16);
      1:       return (k == NTOT - 1) ? W'(1) : W'(15);
      2:       return W'($urandom);
      default: return '0;
    endcase
  endfunction

  task automatic do_load(input int n_beats, input int pat, input int duty);
    int k = 0;
    int cycles = 0;
    int done_cnt = 0;
    int done_at = -1;
    int ready_bad = 0;
    bit v;
    logic [W-1:0] d;
    load_start = 1'b1;
    ld_valid   = 1'b1;
    ld_data    = W'(10);   // presented with load_start, must be dropped
    tick();
    load_start   = 1'b0;
    model_loaded = 1'b0;
    check_val("loaded_after_start", loaded, 0);
    while (k < n_beats && cycles < 8 * n_beats + 100) begin
      v = ($urandom_range(99) < duty);
      d = beat_word(pat, k);
      ld_valid = v;
      ld_data  = d;
      @(negedge clk);
      if (ld_ready !== 1'b1) ready_bad++;
      if (load_done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (v && k == NTOT - 1) check_val("loaded_before_last", loaded, 0);
      tick();
      cycles++;
      if (v) begin
        mem[k] = d;
        k++;
      end
    end
    ld_valid = 1'b0;
    check_val("load_beats", k, n_beats);
    check_val("ld_ready_during_load", ready_bad, 0);
    if (n_beats == NTOT) begin
      model_loaded = 1'b1;
      check_val("load_done_count", done_cnt, 1);
      check_val("load_done_beat", done_at, NTOT - 1);
      check_val("loaded_after_load", loaded, 1);
      check_val("ld_ready_after_load", ld_ready, 0);
      if (duty >= 100) check_val("min_load_cycles", cycles, NTOT);
    end else begin
      check_val("no_done_partial", done_cnt, 0);
      check_val("loaded_partial", loaded, 0);
    end
  endtask

  task automatic do_read(input bit cen, input int ch, input bit den, input int idx);
    bit cok = model_loaded && (ch < CONV_CH);
    bit dok = model_loaded && (idx < DL_IN);
    conv_rd_en = cen;
    conv_rd_ch = CH_W'(ch);
    dl_rd_en   = den;
    dl_rd_idx  = IDX_W'(idx);
    if (cen) begin
      exp_cw = '0;
      exp_cb = '0;
      if (cok) begin
        for (int t = 0; t < NTAP; t++) exp_cw[t*W +: W] = mem[ch*NTAP + t];
        exp_cb = mem[NCW + ch];
      end
    end
    if (den) begin
      exp_dw = '0;
      if (dok)
        for (int o = 0; o < DL_OUT; o++) exp_dw[o*W +: W] = mem[NCW + NCB + idx*DL_OUT + o];
    end
    tick();
    conv_rd_en = 1'b0;
    dl_rd_en   = 1'b0;
    check_val("conv_rd_valid", conv_rd_valid, cen && cok);
    check_val("conv_w", conv_w, exp_cw);
    check_val("conv_b", conv_b, exp_cb);
    check_val("dl_rd_valid", dl_rd_valid, den && dok);
    check_val("dl_w", dl_w, exp_dw);
    check_val("rd_err", rd_err, (cen && !cok) || (den && !dok));
    check_val("dl_b", dl_b, model_db());
  endtask

  task automatic idle_check();
    tick();
    check_val("idle_conv_valid", conv_rd_valid, 0);
    check_val("idle_dl_valid", dl_rd_valid, 0);
    check_val("idle_rd_err", rd_err, 0);
    check_val("hold_conv_w", conv_w, exp_cw);
    check_val("hold_dl_w", dl_w, exp_dw);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++)
      do_read(1'($urandom_range(1)), $urandom_range(3), 1'($urandom_range(1)),
              ($urandom_range(7) == 0) ? 128 + $urandom_range(127) : $urandom_range(127));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NTAP*W-1:0]   tp_cw;
    logic [DL_OUT*W-1:0] tp_dw;
    logic [DL_OUT*W-1:0] tp_db;

    reset = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    conv_rd_en = 1'b0; conv_rd_ch = '0; dl_rd_en = 1'b0; dl_rd_idx = '0;
    exp_cw = '0; exp_cb = '0; exp_dw = '0; model_loaded = 1'b0;
    for (int i = 0; i < NTOT; i++) mem[i] = '0;
    repeat (3) tick();
    reset = 1'b0;

    check_val("rst_ld_ready", ld_ready, 0);
    check_val("rst_loaded", loaded, 0);
    check_val("rst_load_done", load_done, 0);
    check_val("rst_conv_w", conv_w, 0);
    check_val("rst_conv_b", conv_b, 0);
    check_val("rst_conv_valid", conv_rd_valid, 0);
    check_val("rst_dl_w", dl_w, 0);
    check_val("rst_dl_b", dl_b, 0);
    check_val("rst_dl_valid", dl_rd_valid, 0);
    check_val("rst_rd_err", rd_err, 0);

    // Reads before any load are errors.
    do_read(1'b1, 0, 1'b1, 5);
    idle_check();

    // Full load of index mod 16.
    do_load(NTOT, 0, 100);
    do_read(1'b1, 1, 1'b0, 0);
    for (int t = 0; t < NTAP; t++) tp_cw[t*W +: W] = W'((9 + t) % 16);
    check_val("tp_conv_w_ch1", conv_w, tp_cw);
    check_val("tp_conv_b_ch1", conv_b, 3);
    do_read(1'b1, 0, 1'b1, 127);
    for (int o = 0; o < DL_OUT; o++) begin
      tp_dw[o*W +: W] = W'((20 + 1270 + o) % 16);
      tp_db[o*W +: W] = W'((1300 + o) % 16);
    end
    check_val("tp_dl_w_127", dl_w, tp_dw);
    check_val("tp_dl_b", dl_b, tp_db);
    check_val("tp_both_valid", {conv_rd_valid, dl_rd_valid}, 2'b11);
    idle_check();
    do_read(1'b0, 0, 1'b1, 128);
    do_read(1'b1, 2, 1'b0, 0);
    random_reads(30);
    idle_check();

    // Gapped load: ones everywhere, final beat = 1.
    do_load(NTOT, 1, 50);
    check_val("tp_dl_b9", dl_b[9*W +: W], 1);
    random_reads(15);

    // Abandoned load then full zero reload.
    do_load(600, 2, 100);
    do_read(1'b1, 0, 1'b1, 3);
    do_load(NTOT, 3, 100);
    do_read(1'b1, 1, 1'b1, 50);
    check_val("zero_conv_w", conv_w, 0);
    check_val("zero_dl_w", dl_w, 0);
    check_val("zero_dl_b", dl_b, 0);
    random_reads(15);

    // Reset in the middle of a load.
    do_load(100, 2, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_loaded = 1'b0;
    exp_cw = '0; exp_cb = '0; exp_dw = '0;
    check_val("midrst_loaded", loaded, 0);
    check_val("midrst_ld_ready", ld_ready, 0);
    check_val("midrst_conv_w", conv_w, 0);
    check_val("midrst_dl_w", dl_w, 0);
    check_val("midrst_dl_b", dl_b, 0);
    do_read(1'b1, 0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
